// File: rtl/rv_mem_arbiter.sv
// Arbitrates one single-port synchronous SRAM between instruction fetch and data ports.
// The data port has priority; a bounded starve counter guarantees fetch forward progress.
module rv_mem_arbiter #(
  parameter int unsigned AW            = 32,
  parameter int unsigned DM_STARVE_MAX = 4
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          im_req_i,
  input  logic [AW-1:0] im_addr_i,
  input  logic          im_flush_i,
  output logic          im_ack_o,
  output logic [31:0]   im_data_o,
  output logic          im_valid_o,
  input  logic          dm_req_i,
  input  logic [AW-1:0] dm_addr_i,
  input  logic [31:0]   dm_data_s_i,
  input  logic [3:0]    dm_sel_i,
  input  logic          dm_we_i,
  output logic          dm_ack_o,
  output logic [31:0]   dm_data_l_o,
  output logic          dm_valid_o,
  output logic          mem_en_o,
  output logic          mem_we_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [31:0]   mem_data_o,
  output logic [3:0]    mem_sel_o,
  input  logic [31:0]   mem_data_i
);

  localparam int unsigned CW = 4;
  localparam logic [CW-1:0] STARVE_LIM = CW'(DM_STARVE_MAX);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IM   = 2'd1,
    OWN_DM   = 2'd2
  } owner_e;

  owner_e        r_owner;
  owner_e        w_owner_nxt;
  logic [CW-1:0] r_starve;
  logic [CW-1:0] w_starve_nxt;
  logic          w_gnt_dm;
  logic          w_gnt_im;

  // Grants are suppressed while reset is asserted so the RAM sees no access.
  assign w_gnt_dm = rst_n_i & dm_req_i & ~(im_req_i & (r_starve == STARVE_LIM));
  assign w_gnt_im = rst_n_i & im_req_i & ~w_gnt_dm;

  assign im_ack_o = w_gnt_im;
  assign dm_ack_o = w_gnt_dm;

  always_comb begin
    mem_en_o   = 1'b0;
    mem_we_o   = 1'b0;
    mem_addr_o = '0;
    mem_data_o = '0;
    mem_sel_o  = 4'h0;
    if (w_gnt_dm) begin
      mem_en_o   = 1'b1;
      mem_we_o   = dm_we_i;
      mem_addr_o = dm_addr_i;
      mem_data_o = dm_we_i ? dm_data_s_i : 32'h0;
      mem_sel_o  = dm_we_i ? dm_sel_i : 4'hF;
    end else if (w_gnt_im) begin
      mem_en_o   = 1'b1;
      mem_addr_o = im_addr_i;
      mem_sel_o  = 4'hF;
    end
  end

  // Read-owner tracking and starve counter next state.
  always_comb begin
    w_owner_nxt  = OWN_NONE;
    w_starve_nxt = '0;
    if (w_gnt_dm) begin
      if (!dm_we_i) w_owner_nxt = OWN_DM;
      if (im_req_i) w_starve_nxt = (r_starve == STARVE_LIM) ? STARVE_LIM : r_starve + CW'(1);
    end else if (w_gnt_im) begin
      w_owner_nxt = OWN_IM;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_owner  <= OWN_NONE;
      r_starve <= '0;
    end else begin
      r_owner  <= w_owner_nxt;
      r_starve <= w_starve_nxt;
    end
  end

  assign im_valid_o  = (r_owner == OWN_IM) & ~im_flush_i;
  assign dm_valid_o  = (r_owner == OWN_DM);
  assign im_data_o   = mem_data_i;
  assign dm_data_l_o = mem_data_i;

endmodule

// File: tb/tb_rv_mem_arbiter.sv
// Directed bench for rv_mem_arbiter with a write-first RAM and a spec-level reference model.
module tb_rv_mem_arbiter;

  localparam int unsigned AW = 32;
  localparam int STARVE_MAX = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          im_req, im_flush, dm_req, dm_we;
  logic [AW-1:0] im_addr, dm_addr;
  logic [31:0]   dm_data_s;
  logic [3:0]    dm_sel;
  logic          im_ack, im_valid, dm_ack, dm_valid;
  logic [31:0]   im_data, dm_data_l;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata, mem_rdata;
  logic [3:0]    mem_sel;

  int total = 0;
  int bad   = 0;

  rv_mem_arbiter #(.AW(AW), .DM_STARVE_MAX(STARVE_MAX)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .im_req_i(im_req), .im_addr_i(im_addr), .im_flush_i(im_flush),
    .im_ack_o(im_ack), .im_data_o(im_data), .im_valid_o(im_valid),
    .dm_req_i(dm_req), .dm_addr_i(dm_addr), .dm_data_s_i(dm_data_s),
    .dm_sel_i(dm_sel), .dm_we_i(dm_we),
    .dm_ack_o(dm_ack), .dm_data_l_o(dm_data_l), .dm_valid_o(dm_valid),
    .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
    .mem_data_o(mem_wdata), .mem_sel_o(mem_sel), .mem_data_i(mem_rdata)
  );

  always #5 clk = ~clk;

  // Write-first synchronous RAM, 256 words, one-cycle read latency.
  logic [31:0] ram [256];
  initial begin
    logic [31:0] w;
    for (int i = 0; i < 256; i++) ram[i] = 32'hA5A5_0000 | 32'(i);
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      if (mem_en) begin
        w = ram[mem_addr[9:2]];
        if (mem_we)
          for (int b = 0; b < 4; b++)
            if (mem_sel[b]) w[b*8 +: 8] = mem_wdata[b*8 +: 8];
        ram[mem_addr[9:2]] = w;
        mem_rdata <= w;
      end
    end
  end

  // Reference model state: who owns the returning word, what it must be, starve run length.
  logic [31:0] shadow [256];
  int          m_owner;
  int          m_starve;
  logic [31:0] m_exp;
  logic        s_im_ack, s_dm_ack, s_im_valid, s_dm_valid;
  logic [31:0] s_im_data, s_dm_data;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle();
    im_req = 0; im_flush = 0; dm_req = 0; dm_we = 0;
    im_addr = '0; dm_addr = '0; dm_data_s = '0; dm_sel = 4'h0;
  endtask

  // One cycle: inputs already applied after negedge; compare, then advance the model at posedge.
  task automatic step();
    logic e_dm, e_im, e_imv, e_dmv;
    logic [31:0] e_data;
    logic [3:0]  e_sel;
    logic [AW-1:0] e_addr;
    logic [31:0] w;
    if (!rst_n) begin m_owner = 0; m_starve = 0; end
    #2;
    e_dm  = rst_n && dm_req && !(im_req && m_starve == STARVE_MAX);
    e_im  = rst_n && im_req && !e_dm;
    e_imv = rst_n && m_owner == 1 && !im_flush;
    e_dmv = rst_n && m_owner == 2;
    e_addr = e_dm ? dm_addr : (e_im ? im_addr : '0);
    e_sel  = e_dm ? (dm_we ? dm_sel : 4'hF) : (e_im ? 4'hF : 4'h0);
    e_data = (e_dm && dm_we) ? dm_data_s : 32'h0;
    s_im_ack = im_ack; s_dm_ack = dm_ack; s_im_valid = im_valid; s_dm_valid = dm_valid;
    s_im_data = im_data; s_dm_data = dm_data_l;
    chk("im_ack", 32'(im_ack), 32'(e_im));
    chk("dm_ack", 32'(dm_ack), 32'(e_dm));
    chk("mem_en", 32'(mem_en), 32'(e_dm | e_im));
    chk("mem_we", 32'(mem_we), 32'(e_dm & dm_we));
    chk("mem_addr", mem_addr, e_addr);
    chk("mem_sel", 32'(mem_sel), 32'(e_sel));
    if (!(e_dm && !dm_we)) chk("mem_wdata", mem_wdata, e_data);
    chk("im_valid", 32'(im_valid), 32'(e_imv));
    chk("dm_valid", 32'(dm_valid), 32'(e_dmv));
    if (e_imv) chk("im_data", im_data, m_exp);
    if (e_dmv) chk("dm_data", dm_data_l, m_exp);
    @(posedge clk);
    if (!rst_n) begin
      m_owner = 0; m_starve = 0;
    end else if (e_dm) begin
      if (dm_we) begin
        w = shadow[dm_addr[9:2]];
        for (int b = 0; b < 4; b++) if (dm_sel[b]) w[b*8 +: 8] = dm_data_s[b*8 +: 8];
        shadow[dm_addr[9:2]] = w;
        m_owner = 0;
      end else begin
        m_owner = 2;
        m_exp   = shadow[dm_addr[9:2]];
      end
      m_starve = im_req ? ((m_starve + 1 > STARVE_MAX) ? STARVE_MAX : m_starve + 1) : 0;
    end else if (e_im) begin
      m_owner = 1; m_exp = shadow[im_addr[9:2]]; m_starve = 0;
    end else begin
      m_owner = 0; m_starve = 0;
    end
    @(negedge clk);
  endtask

  task automatic fetch(input logic [AW-1:0] a);
    idle(); im_req = 1; im_addr = a;
  endtask

  task automatic dload(input logic [AW-1:0] a);
    dm_req = 1; dm_we = 0; dm_addr = a; dm_sel = 4'h0; dm_data_s = '0;
  endtask

  initial begin
    int n_dm, n_im;
    for (int i = 0; i < 256; i++) shadow[i] = 32'hA5A5_0000 | 32'(i);
    m_owner = 0; m_starve = 0; m_exp = '0;
    idle(); rst_n = 0;
    @(negedge clk);
    step(); step();
    rst_n = 1;
    step();

    // Fetch stream alone
    fetch(32'h0); step();
    fetch(32'h4); step();
    fetch(32'h8); step();
    chk("lit_fetch4_data", s_im_data, 32'hA5A5_0001);
    idle(); step();
    chk("lit_fetch8_valid", 32'(s_im_valid), 32'd1);
    chk("lit_fetch8_data", s_im_data, 32'hA5A5_0002);

    // Simultaneous requests: data wins, fetch follows
    fetch(32'hC); dload(32'h100); step();
    chk("lit_both_dm_ack", 32'(s_dm_ack), 32'd1);
    chk("lit_both_im_ack", 32'(s_im_ack), 32'd0);
    fetch(32'hC); step();
    chk("lit_im_after_dm", 32'(s_im_ack), 32'd1);
    chk("lit_dm_valid", 32'(s_dm_valid), 32'd1);
    chk("lit_dm_data_100", s_dm_data, 32'hA5A5_0040);
    idle(); step();

    // Starvation bound: 4 data grants then 1 fetch grant
    n_dm = 0; n_im = 0;
    for (int c = 0; c < 10; c++) begin
      fetch(32'h10); dload(32'(32'h200 + 4 * c)); step();
      n_dm += int'(s_dm_ack); n_im += int'(s_im_ack);
      if (c == 4 || c == 9) chk("lit_starve_im_slot", 32'(s_im_ack), 32'd1);
    end
    chk("lit_starve_dm_cnt", 32'(n_dm), 32'd8);
    chk("lit_starve_im_cnt", 32'(n_im), 32'd2);
    idle(); step();

    // Partial store then load of the same word
    idle(); dm_req = 1; dm_we = 1; dm_addr = 32'h40; dm_data_s = 32'hDEAD_BEEF; dm_sel = 4'b0011; step();
    idle(); dload(32'h40); step();
    chk("lit_store_no_valid", 32'(s_dm_valid), 32'd0);
    idle(); step();
    chk("lit_merge_data", s_dm_data, 32'hA5A5_BEEF);

    // Flush kills the in-flight fetch only
    fetch(32'h14); step();
    idle(); im_flush = 1; step();
    chk("lit_flush_valid", 32'(s_im_valid), 32'd0);
    fetch(32'h18); step();
    idle(); step();
    chk("lit_after_flush_data", s_im_data, 32'hA5A5_0006);

    // Reset while a load is in flight
    idle(); dload(32'h100); step();
    rst_n = 0; step();
    chk("lit_rst_dm_valid", 32'(s_dm_valid), 32'd0);
    chk("lit_rst_dm_ack", 32'(s_dm_ack), 32'd0);
    idle(); rst_n = 1; step();
    chk("lit_post_rst_valid", 32'(s_dm_valid), 32'd0);
    dload(32'h8); step();
    chk("lit_post_rst_ack", 32'(s_dm_ack), 32'd1);
    idle(); step();
    chk("lit_post_rst_data", s_dm_data, 32'hA5A5_0002);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
